// File: rtl/video_stream_region_modifier_if.sv
// AXI4-Stream video bundle shared by the region modifier and its neighbours.
// TUSER marks start-of-frame and TLAST marks end-of-line.
interface video_stream_region_modifier_if #(
  parameter int DATA_W = 24
);
  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_W-1:0]     TDATA;
  logic [DATA_W/8-1:0]   TKEEP;
  logic [DATA_W/8-1:0]   TSTRB;
  logic                  TUSER;
  logic                  TLAST;
  logic                  TID;
  logic                  TDEST;

  modport master (
    output TVALID, TDATA, TKEEP, TSTRB, TUSER, TLAST, TID, TDEST,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TKEEP, TSTRB, TUSER, TLAST, TID, TDEST,
    output TREADY
  );
endinterface

// File: rtl/video_stream_region_modifier.sv
// Per-pixel pass/XOR/fill/invert inside a programmable rectangle on an AXI4-Stream
// video path; control is latched at start-of-frame, output is a single register stage.
module video_stream_region_modifier #(
  parameter int DATA_W  = 24,
  parameter int COORD_W = 12
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [1:0]                     ctl_mode,
  input  logic [DATA_W-1:0]              ctl_value,
  input  logic [COORD_W-1:0]             ctl_x0,
  input  logic [COORD_W-1:0]             ctl_x1,
  input  logic [COORD_W-1:0]             ctl_y0,
  input  logic [COORD_W-1:0]             ctl_y1,
  video_stream_region_modifier_if.slave  s_axis_video,
  video_stream_region_modifier_if.master m_axis_video,
  output logic [15:0]                    frame_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int CTL_W  = 2 + DATA_W + 4 * COORD_W;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_XOR  = 2'd1;
  localparam logic [1:0] MODE_FILL = 2'd2;
  localparam logic [1:0] MODE_INV  = 2'd3;

  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] COORD_MAX  = {COORD_W{1'b1}};

  typedef struct packed {
    logic [1:0]         mode;
    logic [DATA_W-1:0]  value;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
  } ctl_t;

  localparam ctl_t CTL_ZERO = {CTL_W{1'b0}};

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    logic [COORD_W-1:0] r;
    if (v == COORD_MAX) begin
      r = COORD_MAX;
    end else begin
      r = v + COORD_ONE;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] apply_op(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] value,
    input logic [DATA_W-1:0] pix,
    input logic              hit
  );
    logic [DATA_W-1:0] r;
    r = pix;
    if (hit) begin
      case (mode)
        MODE_PASS: r = pix;
        MODE_XOR:  r = pix ^ value;
        MODE_FILL: r = value;
        MODE_INV:  r = ~pix;
        default:   r = pix;
      endcase
    end else begin
      r = pix;
    end
    return r;
  endfunction

  ctl_t                ctl_in_s;
  ctl_t                sync0_r;
  ctl_t                shadow_r;
  ctl_t                active_r;
  ctl_t                eff_s;
  logic [COORD_W-1:0]  x_r, y_r;
  logic [COORD_W-1:0]  cur_x_s, cur_y_s, x_nxt_s, y_nxt_s;
  logic                s_tready_s;
  logic                accept_s;
  logic                hit_s;
  logic [DATA_W-1:0]   pix_s;
  logic [15:0]         frame_count_r;

  logic                m_valid_r;
  logic [DATA_W-1:0]   m_data_r;
  logic [KEEP_W-1:0]   m_keep_r;
  logic [KEEP_W-1:0]   m_strb_r;
  logic                m_user_r;
  logic                m_last_r;
  logic                m_id_r;
  logic                m_dest_r;

  // Handshake, effective control set, coordinates and pixel result for the input beat
  always_comb begin
    ctl_in_s   = '{mode: ctl_mode, value: ctl_value,
                   x0: ctl_x0, x1: ctl_x1, y0: ctl_y0, y1: ctl_y1};
    s_tready_s = !areset && (!m_valid_r || m_axis_video.TREADY);
    accept_s   = s_axis_video.TVALID && s_tready_s;
    // An SOF beat uses the freshly loaded set and is pinned to (0,0)
    if (s_axis_video.TUSER) begin
      eff_s   = shadow_r;
      cur_x_s = COORD_ZERO;
      cur_y_s = COORD_ZERO;
    end else begin
      eff_s   = active_r;
      cur_x_s = x_r;
      cur_y_s = y_r;
    end
    hit_s = (cur_x_s >= eff_s.x0) && (cur_x_s <= eff_s.x1) &&
            (cur_y_s >= eff_s.y0) && (cur_y_s <= eff_s.y1);
    pix_s = apply_op(eff_s.mode, eff_s.value, s_axis_video.TDATA, hit_s);
    if (s_axis_video.TLAST) begin
      x_nxt_s = COORD_ZERO;
      y_nxt_s = sat_inc(cur_y_s);
    end else begin
      x_nxt_s = sat_inc(cur_x_s);
      y_nxt_s = cur_y_s;
    end
  end

  // Two-stage capture of the quasi-static control word
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync0_r  <= CTL_ZERO;
      shadow_r <= CTL_ZERO;
    end else begin
      sync0_r  <= ctl_in_s;
      shadow_r <= sync0_r;
    end
  end

  // Frame state: active set, coordinates and SOF counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      active_r      <= CTL_ZERO;
      x_r           <= COORD_ZERO;
      y_r           <= COORD_ZERO;
      frame_count_r <= 16'd0;
    end else if (accept_s) begin
      x_r <= x_nxt_s;
      y_r <= y_nxt_s;
      if (s_axis_video.TUSER) begin
        active_r      <= shadow_r;
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

  // Output register: reload on accept, drop valid once drained
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_valid_r <= 1'b0;
      m_data_r  <= {DATA_W{1'b0}};
      m_keep_r  <= {KEEP_W{1'b0}};
      m_strb_r  <= {KEEP_W{1'b0}};
      m_user_r  <= 1'b0;
      m_last_r  <= 1'b0;
      m_id_r    <= 1'b0;
      m_dest_r  <= 1'b0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= pix_s;
      m_keep_r  <= s_axis_video.TKEEP;
      m_strb_r  <= s_axis_video.TSTRB;
      m_user_r  <= s_axis_video.TUSER;
      m_last_r  <= s_axis_video.TLAST;
      m_id_r    <= s_axis_video.TID;
      m_dest_r  <= s_axis_video.TDEST;
    end else if (m_axis_video.TREADY) begin
      m_valid_r <= 1'b0;
    end
  end

  assign s_axis_video.TREADY = s_tready_s;
  assign m_axis_video.TVALID = m_valid_r;
  assign m_axis_video.TDATA  = m_data_r;
  assign m_axis_video.TKEEP  = m_keep_r;
  assign m_axis_video.TSTRB  = m_strb_r;
  assign m_axis_video.TUSER  = m_user_r;
  assign m_axis_video.TLAST  = m_last_r;
  assign m_axis_video.TID    = m_id_r;
  assign m_axis_video.TDEST  = m_dest_r;
  assign frame_count         = frame_count_r;

endmodule

// File: tb/tb_video_stream_region_modifier.sv
// Directed bench for video_stream_region_modifier: hand-computed expected pixels are
// queued per beat and compared against every output transfer.
module tb_video_stream_region_modifier;

  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic [1:0]  ctl_mode;
  logic [23:0] ctl_value;
  logic [11:0] ctl_x0, ctl_x1, ctl_y0, ctl_y1;
  logic [15:0] frame_count;
  logic        bp_en = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  logic [33:0] exp_q[$];

  always #5 aclk = ~aclk;

  video_stream_region_modifier_if #(.DATA_W(24)) s_if ();
  video_stream_region_modifier_if #(.DATA_W(24)) m_if ();

  video_stream_region_modifier #(.DATA_W(24), .COORD_W(12)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .ctl_mode     (ctl_mode),
    .ctl_value    (ctl_value),
    .ctl_x0       (ctl_x0),
    .ctl_x1       (ctl_x1),
    .ctl_y0       (ctl_y0),
    .ctl_y1       (ctl_y1),
    .s_axis_video (s_if.slave),
    .m_axis_video (m_if.master),
    .frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_vec++;
    if (obs !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, req);
    end
  endtask

  // Sideband is derived from the input data so that copying can be checked
  function automatic logic [33:0] pack_exp(input logic [23:0] d_in, input logic [23:0] d_out,
                                           input logic u, input logic l);
    return {d_in[0], d_in[1], 3'b111, d_in[4:2], u, l, d_out};
  endfunction

  function automatic logic [33:0] obs_now();
    return {m_if.TID, m_if.TDEST, m_if.TKEEP, m_if.TSTRB, m_if.TUSER, m_if.TLAST, m_if.TDATA};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic set_ctl(input logic [1:0] mode, input logic [23:0] value,
                         input logic [11:0] x0, input logic [11:0] x1,
                         input logic [11:0] y0, input logic [11:0] y1);
    ctl_mode = mode; ctl_value = value;
    ctl_x0 = x0; ctl_x1 = x1; ctl_y0 = y0; ctl_y1 = y1;
    idle(5);
  endtask

  task automatic send(input logic [23:0] d, input logic u, input logic l, input logic [23:0] d_out);
    int guard;
    guard = 0;
    s_if.TVALID = 1'b1; s_if.TDATA = d; s_if.TUSER = u; s_if.TLAST = l;
    s_if.TKEEP = 3'b111; s_if.TSTRB = d[4:2]; s_if.TID = d[0]; s_if.TDEST = d[1];
    exp_q.push_back(pack_exp(d, d_out, u, l));
    @(negedge aclk);
    while (!s_if.TREADY && guard < 100) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 100) check("s_tready_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    s_if.TVALID = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge aclk);
      guard++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output ready generator: always ready, or 50% random under backpressure
  initial begin
    m_if.TREADY = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.TREADY = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor on the falling edge: handshake rule, stall stability, beat scoreboard
  initial begin
    logic [33:0] stall_data;
    logic        stall_v;
    logic [33:0] e;
    stall_v = 1'b0;
    stall_data = 34'd0;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        check("s_tready", {63'd0, s_if.TREADY}, {63'd0, (!m_if.TVALID || m_if.TREADY)});
        if (stall_v) check("stall_hold", {29'd0, m_if.TVALID, obs_now()}, {29'd0, 1'b1, stall_data});
        if (m_if.TVALID && m_if.TREADY) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", {30'd0, obs_now()}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat", {30'd0, obs_now()}, {30'd0, e});
          end
        end
        stall_v    = m_if.TVALID && !m_if.TREADY;
        stall_data = obs_now();
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [23:0] d;
    s_if.TVALID = 1'b0; s_if.TDATA = 24'd0; s_if.TKEEP = 3'd0; s_if.TSTRB = 3'd0;
    s_if.TUSER = 1'b0; s_if.TLAST = 1'b0; s_if.TID = 1'b0; s_if.TDEST = 1'b0;
    ctl_mode = 2'd0; ctl_value = 24'd0;
    ctl_x0 = 12'd0; ctl_x1 = 12'hFFF; ctl_y0 = 12'd0; ctl_y1 = 12'hFFF;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_m_tvalid", {63'd0, m_if.TVALID}, 64'd0);
    check("rst_s_tready", {63'd0, s_if.TREADY}, 64'd0);
    check("rst_m_tdata", {40'd0, m_if.TDATA}, 64'd0);
    check("rst_frame_count", {48'd0, frame_count}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Pass-through 4x2 frame with one-cycle latency
    set_ctl(2'd0, 24'd0, 12'd0, 12'hFFF, 12'd0, 12'hFFF);
    for (int i = 1; i <= 8; i++) begin
      send(24'(i), i == 1, (i % 4) == 0, 24'(i));
      if (i == 1) check("latency", {39'd0, m_if.TVALID, m_if.TDATA}, {39'd0, 1'b1, 24'h000001});
    end
    drain();
    check("fc_pass", {48'd0, frame_count}, 64'd1);

    // XOR inside x 1..2, y 1..1 on a 4x3 frame
    set_ctl(2'd1, 24'hFFFFFF, 12'd1, 12'd2, 12'd1, 12'd1);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        send(24'h123456, (x == 0) && (y == 0), x == 3,
             ((x >= 1) && (x <= 2) && (y == 1)) ? 24'hEDCBA9 : 24'h123456);
    drain();
    check("fc_xor", {48'd0, frame_count}, 64'd2);

    // Frame atomicity: value changes mid-frame, takes effect at the next SOF
    set_ctl(2'd2, 24'hAA0000, 12'd0, 12'hFFF, 12'd0, 12'hFFF);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) ctl_value = 24'h00BB00;
      send(24'(i), i == 0, (i % 4) == 3, 24'hAA0000);
    end
    idle(6);
    for (int i = 0; i < 8; i++) send(24'(i + 16), i == 0, (i % 4) == 3, 24'h00BB00);
    drain();
    check("fc_atomic", {48'd0, frame_count}, 64'd4);

    // Backpressure: 8x8 pass frame with random output ready
    set_ctl(2'd0, 24'd0, 12'd0, 12'hFFF, 12'd0, 12'hFFF);
    bp_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = {8'(i), ~8'(i), 8'(i * 3)};
      send(d, i == 0, (i % 8) == 7, d);
    end
    drain();
    bp_en = 1'b0;
    idle(2);
    check("fc_bp", {48'd0, frame_count}, 64'd5);

    // Invert with an empty region, then with x 0..3
    set_ctl(2'd3, 24'd0, 12'd5, 12'd2, 12'd0, 12'hFFF);
    for (int i = 0; i < 4; i++) send(24'h0F0F0F, i == 0, i == 3, 24'h0F0F0F);
    drain();
    set_ctl(2'd3, 24'd0, 12'd0, 12'd3, 12'd0, 12'hFFF);
    for (int i = 0; i < 6; i++) send(24'h0F0F0F, i == 0, i == 5, (i <= 3) ? 24'hF0F0F0 : 24'h0F0F0F);
    drain();
    check("fc_inv", {48'd0, frame_count}, 64'd7);

    // SOF and TLAST on the same beat: next beat is row 1
    set_ctl(2'd2, 24'h123456, 12'd0, 12'd0, 12'd1, 12'd1);
    send(24'h0000A1, 1'b1, 1'b1, 24'h0000A1);
    send(24'h0000A2, 1'b0, 1'b1, 24'h123456);
    send(24'h0000A3, 1'b0, 1'b1, 24'h0000A3);
    drain();
    check("fc_soflast", {48'd0, frame_count}, 64'd8);

    // x counter saturates at 4095 on a long line
    set_ctl(2'd2, 24'h55AA55, 12'hFFF, 12'hFFF, 12'd0, 12'd0);
    for (int i = 0; i < 4100; i++) send(24'(i), i == 0, i == 4099, (i >= 4095) ? 24'h55AA55 : 24'(i));
    drain();
    check("fc_sat", {48'd0, frame_count}, 64'd9);

    // Reset during beat 3 of a fill frame
    set_ctl(2'd2, 24'h00FF00, 12'd0, 12'hFFF, 12'd0, 12'hFFF);
    for (int i = 0; i < 3; i++) send(24'(i + 32), i == 0, 1'b0, 24'h00FF00);
    s_if.TVALID = 1'b1; s_if.TDATA = 24'd35; s_if.TUSER = 1'b0; s_if.TLAST = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", {63'd0, m_if.TVALID}, 64'd0);
    check("mid_rst_s_tready", {63'd0, s_if.TREADY}, 64'd0);
    check("mid_rst_frame_count", {48'd0, frame_count}, 64'd0);
    s_if.TVALID = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    idle(4);
    for (int i = 0; i < 4; i++) send(24'(i + 36), 1'b0, i == 3, 24'(i + 36));
    drain();
    idle(2);
    for (int i = 0; i < 3; i++) send(24'(i + 48), i == 0, i == 2, 24'h00FF00);
    drain();
    check("fc_after_rst", {48'd0, frame_count}, 64'd1);

    idle(3);
    check("q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
